// File: rtl/dance_pkg.sv
// Shared types and constants for the LED chaser observer.
package dance_pkg;

  localparam int unsigned NUM_LEDS = 18;
  localparam int unsigned POS_W    = 5;

  typedef enum logic [1:0] {
    MODE_UNKNOWN = 2'd0,
    MODE_UP      = 2'd1,
    MODE_DOWN    = 2'd2,
    MODE_BOUNCE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SMP_ONE,
    SMP_BLANK,
    SMP_MULTI
  } sample_t;

  typedef enum logic [1:0] {
    STEP_STAY,
    STEP_INC,
    STEP_DEC,
    STEP_JUMP
  } step_t;

endpackage

// File: rtl/onehot_decode.sv
// Combinational classifier of the LED vector: lit index plus one/blank/multi flags.
module onehot_decode #(
  parameter int unsigned NUM_LEDS = dance_pkg::NUM_LEDS,
  parameter int unsigned POS_W    = dance_pkg::POS_W
) (
  input  logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    idx,
  output logic                is_one,
  output logic                is_blank,
  output logic                is_multi
);

  logic seen;
  logic dup;

  always_comb begin
    idx  = '0;
    seen = 1'b0;
    dup  = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (led[i]) begin
        if (seen) dup = 1'b1;
        seen = 1'b1;
        idx  = POS_W'(i);
      end
    end
    is_one   = seen & ~dup;
    is_blank = ~seen;
    is_multi = dup;
  end

endmodule

// File: rtl/dance_monitor.sv
// Watches the chaser LED bus: tracks lit position, infers chase mode, counts laps
// and latches a sticky flag on illegal patterns.
module dance_monitor #(
  parameter int unsigned NUM_LEDS = dance_pkg::NUM_LEDS,
  parameter int unsigned POS_W    = dance_pkg::POS_W
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [NUM_LEDS-1:0] led,
  input  logic                sample_en,
  input  logic                err_clr,
  output logic [POS_W-1:0]    position,
  output logic                valid,
  output logic [1:0]          mode,
  output logic                error,
  output logic [7:0]          lap_count
);

  import dance_pkg::*;

  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

  logic [POS_W-1:0] idx;
  logic             is_one, is_blank, is_multi;

  onehot_decode #(
    .NUM_LEDS(NUM_LEDS),
    .POS_W   (POS_W)
  ) u_decode (
    .led     (led),
    .idx     (idx),
    .is_one  (is_one),
    .is_blank(is_blank),
    .is_multi(is_multi)
  );

  mode_t            mode_q, mode_n;
  logic [POS_W-1:0] prev_q, prev_n;
  logic             valid_q, valid_n;
  logic             error_q;
  logic [7:0]       lap_q;
  logic             last_one_q, last_one_n;
  logic [1:0]       blank_q, blank_n;
  logic             run_armed_q, run_armed_n;
  logic             run_up_q, run_up_n;
  logic             bdir_up_q, bdir_up_n;
  logic             lap_inc;
  logic             new_err;
  sample_t          cls;
  step_t            step;
  logic             have_step;

  always_comb begin
    cls = SMP_MULTI;
    if (is_one) cls = SMP_ONE;
    else if (is_blank && !is_multi) cls = SMP_BLANK;

    step = STEP_JUMP;
    if (idx == prev_q) step = STEP_STAY;
    else if (idx == prev_q + 1'b1) step = STEP_INC;
    else if (idx + 1'b1 == prev_q) step = STEP_DEC;

    have_step = is_one & last_one_q;
  end

  // prev_q doubles as the position output: both hold the last ONE index.
  always_comb begin
    mode_n      = mode_q;
    prev_n      = prev_q;
    valid_n     = valid_q;
    last_one_n  = last_one_q;
    blank_n     = blank_q;
    run_armed_n = run_armed_q;
    run_up_n    = run_up_q;
    bdir_up_n   = bdir_up_q;
    lap_inc     = 1'b0;
    new_err     = 1'b0;

    if (sample_en) begin
      unique case (cls)
        SMP_MULTI: begin
          new_err     = 1'b1;
          valid_n     = 1'b0;
          mode_n      = MODE_UNKNOWN;
          last_one_n  = 1'b0;
          blank_n     = '0;
          run_armed_n = 1'b0;
        end
        SMP_BLANK: begin
          valid_n     = 1'b0;
          last_one_n  = 1'b0;
          run_armed_n = 1'b0;
          if (blank_q != 2'd0) begin
            mode_n  = MODE_UNKNOWN;
            blank_n = 2'd2;
          end else begin
            blank_n = 2'd1;
          end
        end
        SMP_ONE: begin
          prev_n      = idx;
          valid_n     = 1'b1;
          last_one_n  = 1'b1;
          blank_n     = '0;
          run_armed_n = 1'b0;
          unique case (mode_q)
            MODE_UNKNOWN: begin
              if (have_step && (step == STEP_INC || step == STEP_DEC)) begin
                if (run_armed_q && (run_up_q == (step == STEP_INC))) begin
                  mode_n = (step == STEP_INC) ? MODE_UP : MODE_DOWN;
                end else begin
                  run_armed_n = 1'b1;
                  run_up_n    = (step == STEP_INC);
                end
              end
            end
            MODE_UP: begin
              if (have_step) begin
                unique case (step)
                  STEP_STAY, STEP_INC: ;
                  STEP_DEC: begin
                    if (prev_q == LAST) begin
                      mode_n    = MODE_BOUNCE;
                      bdir_up_n = 1'b0;
                    end else begin
                      new_err = 1'b1;
                      mode_n  = MODE_UNKNOWN;
                    end
                  end
                  STEP_JUMP: begin
                    if (prev_q == LAST && idx == '0) lap_inc = 1'b1;
                    else begin
                      new_err = 1'b1;
                      mode_n  = MODE_UNKNOWN;
                    end
                  end
                endcase
              end else if (blank_q == 2'd1 && prev_q == LAST && idx == '0) begin
                lap_inc = 1'b1;
              end
            end
            MODE_DOWN: begin
              if (have_step) begin
                unique case (step)
                  STEP_STAY, STEP_DEC: ;
                  STEP_INC: begin
                    if (prev_q == '0) begin
                      mode_n    = MODE_BOUNCE;
                      bdir_up_n = 1'b1;
                    end else begin
                      new_err = 1'b1;
                      mode_n  = MODE_UNKNOWN;
                    end
                  end
                  STEP_JUMP: begin
                    if (prev_q == '0 && idx == LAST) lap_inc = 1'b1;
                    else begin
                      new_err = 1'b1;
                      mode_n  = MODE_UNKNOWN;
                    end
                  end
                endcase
              end else if (blank_q == 2'd1 && prev_q == '0 && idx == LAST) begin
                lap_inc = 1'b1;
              end
            end
            MODE_BOUNCE: begin
              if (have_step) begin
                unique case (step)
                  STEP_STAY: ;
                  STEP_INC: begin
                    if (!bdir_up_q) begin
                      if (prev_q == '0) begin
                        bdir_up_n = 1'b1;
                        lap_inc   = 1'b1;
                      end else begin
                        new_err = 1'b1;
                        mode_n  = MODE_UNKNOWN;
                      end
                    end
                  end
                  STEP_DEC: begin
                    if (bdir_up_q) begin
                      if (prev_q == LAST) bdir_up_n = 1'b0;
                      else begin
                        new_err = 1'b1;
                        mode_n  = MODE_UNKNOWN;
                      end
                    end
                  end
                  STEP_JUMP: begin
                    new_err = 1'b1;
                    mode_n  = MODE_UNKNOWN;
                  end
                endcase
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mode_q      <= MODE_UNKNOWN;
      prev_q      <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      lap_q       <= '0;
      last_one_q  <= 1'b0;
      blank_q     <= '0;
      run_armed_q <= 1'b0;
      run_up_q    <= 1'b0;
      bdir_up_q   <= 1'b0;
    end else begin
      mode_q      <= mode_n;
      prev_q      <= prev_n;
      valid_q     <= valid_n;
      error_q     <= new_err | (error_q & ~err_clr);
      last_one_q  <= last_one_n;
      blank_q     <= blank_n;
      run_armed_q <= run_armed_n;
      run_up_q    <= run_up_n;
      bdir_up_q   <= bdir_up_n;
      if (lap_inc && lap_q != 8'hFF) lap_q <= lap_q + 8'd1;
    end
  end

  assign position  = prev_q;
  assign valid     = valid_q;
  assign mode      = mode_q;
  assign error     = error_q;
  assign lap_count = lap_q;

endmodule

// File: tb/tb_dance_monitor.sv
// Directed scoreboard bench for dance_monitor: expectations queued with each sample.
module tb_dance_monitor;

  localparam logic [1:0] MU = 2'd0, MUP = 2'd1, MDN = 2'd2, MBO = 2'd3;

  logic        Clock;
  logic        Resetn;
  logic [17:0] led;
  logic        sample_en;
  logic        err_clr;
  logic [4:0]  position;
  logic        valid;
  logic [1:0]  mode;
  logic        error;
  logic [7:0]  lap_count;

  dance_monitor dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .led      (led),
    .sample_en(sample_en),
    .err_clr  (err_clr),
    .position (position),
    .valid    (valid),
    .mode     (mode),
    .error    (error),
    .lap_count(lap_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit         chk;
    string      tag;
    logic [1:0] m;
    logic [4:0] p;
    logic       v;
    logic       e;
    logic [7:0] l;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(string t, logic [1:0] m, int p, logic v, logic e, int l);
    exp_t r;
    r.chk = 1'b1;
    r.tag = t;
    r.m   = m;
    r.p   = 5'(p);
    r.v   = v;
    r.e   = e;
    r.l   = 8'(l);
    return r;
  endfunction

  function automatic exp_t nc();
    exp_t r;
    r     = mk("none", MU, 0, 1'b0, 1'b0, 0);
    r.chk = 1'b0;
    return r;
  endfunction

  function automatic logic [17:0] oh(int i);
    logic [17:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic compare_out(input exp_t x);
    checks++;
    assert (mode === x.m) else begin
      errors++;
      $error("FAIL %s mode got=%0d exp=%0d", x.tag, mode, x.m);
    end
    checks++;
    assert (position === x.p) else begin
      errors++;
      $error("FAIL %s position got=%0d exp=%0d", x.tag, position, x.p);
    end
    checks++;
    assert (valid === x.v) else begin
      errors++;
      $error("FAIL %s valid got=%0b exp=%0b", x.tag, valid, x.v);
    end
    checks++;
    assert (error === x.e) else begin
      errors++;
      $error("FAIL %s error got=%0b exp=%0b", x.tag, error, x.e);
    end
    checks++;
    assert (lap_count === x.l) else begin
      errors++;
      $error("FAIL %s lap_count got=%0d exp=%0d", x.tag, lap_count, x.l);
    end
  endtask

  // Outputs seen at this negedge belong to the sample driven one cycle earlier.
  task automatic tick(input logic en, input logic clr, input logic [17:0] lv, input exp_t x);
    exp_t y;
    @(negedge Clock);
    if (sb.size() > 0) begin
      y = sb.pop_front();
      if (y.chk) compare_out(y);
    end
    sample_en = en;
    err_clr   = clr;
    led       = lv;
    sb.push_back(x);
  endtask

  task automatic do_reset(input string t);
    tick(1'b0, 1'b0, led, nc());
    tick(1'b0, 1'b0, led, nc());
    sb.delete();
    #2 Resetn = 1'b0;
    #1 compare_out(mk(t, MU, 0, 1'b0, 1'b0, 0));
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    exp_t x;
    Resetn    = 1'b0;
    sample_en = 1'b0;
    err_clr   = 1'b0;
    led       = '0;
    #1 compare_out(mk("reset", MU, 0, 1'b0, 1'b0, 0));
    @(negedge Clock);
    Resetn = 1'b1;

    // UP chase with a blank-bridged wrap
    for (int i = 0; i < 18; i++) begin
      x = nc();
      if (i == 1)  x = mk("up_i1", MU, 1, 1'b1, 1'b0, 0);
      if (i == 2)  x = mk("up_enter", MUP, 2, 1'b1, 1'b0, 0);
      if (i == 17) x = mk("up_top", MUP, 17, 1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, oh(i), x);
    end
    tick(1'b1, 1'b0, '0, mk("up_blank", MUP, 17, 1'b0, 1'b0, 0));
    tick(1'b1, 1'b0, oh(0), mk("up_wrap", MUP, 0, 1'b1, 1'b0, 1));
    tick(1'b1, 1'b0, oh(1), mk("up_after", MUP, 1, 1'b1, 1'b0, 1));
    do_reset("mid_reset");

    // DOWN chase with direct wrap
    for (int i = 17; i >= 0; i--) begin
      x = nc();
      if (i == 17) x = mk("dn_first", MU, 17, 1'b1, 1'b0, 0);
      if (i == 15) x = mk("dn_enter", MDN, 15, 1'b1, 1'b0, 0);
      if (i == 0)  x = mk("dn_bottom", MDN, 0, 1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, oh(i), x);
    end
    tick(1'b1, 1'b0, oh(17), mk("dn_wrap", MDN, 17, 1'b1, 1'b0, 1));
    do_reset("reset_dn");

    // Bounce: 0..17..0..5
    for (int i = 0; i < 18; i++)
      tick(1'b1, 1'b0, oh(i), (i == 17) ? mk("bo_up", MUP, 17, 1'b1, 1'b0, 0) : nc());
    for (int i = 16; i >= 0; i--) begin
      x = nc();
      if (i == 16) x = mk("bo_enter", MBO, 16, 1'b1, 1'b0, 0);
      if (i == 0)  x = mk("bo_bottom", MBO, 0, 1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, oh(i), x);
    end
    for (int i = 1; i <= 5; i++) begin
      x = nc();
      if (i == 1) x = mk("bo_rev0", MBO, 1, 1'b1, 1'b0, 1);
      if (i == 5) x = mk("bo_end", MBO, 5, 1'b1, 1'b0, 1);
      tick(1'b1, 1'b0, oh(i), x);
    end
    do_reset("reset_bo");

    // No history after reset, then illegal reversal mid-run
    for (int i = 1; i <= 8; i++) begin
      x = nc();
      if (i == 2) x = mk("nohist", MU, 2, 1'b1, 1'b0, 0);
      if (i == 3) x = mk("ill_up", MUP, 3, 1'b1, 1'b0, 0);
      if (i == 8) x = mk("ill_at8", MUP, 8, 1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, oh(i), x);
    end
    tick(1'b1, 1'b0, oh(7), mk("ill_rev", MU, 7, 1'b1, 1'b1, 0));
    tick(1'b0, 1'b1, oh(7), mk("err_clr", MU, 7, 1'b1, 1'b0, 0));

    // MULTI with simultaneous clear, then idle detection
    tick(1'b1, 1'b1, 18'h00003, mk("multi_clr", MU, 7, 1'b0, 1'b1, 0));
    tick(1'b0, 1'b1, '0, mk("clr2", MU, 7, 1'b0, 1'b0, 0));
    for (int i = 0; i <= 3; i++) begin
      x = nc();
      if (i == 0) x = mk("idle_first", MU, 0, 1'b1, 1'b0, 0);
      if (i == 3) x = mk("idle_up", MUP, 3, 1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, oh(i), x);
    end
    tick(1'b1, 1'b0, '0, mk("blank1", MUP, 3, 1'b0, 1'b0, 0));
    tick(1'b1, 1'b0, '0, mk("blank2", MU, 3, 1'b0, 1'b0, 0));

    // Gated samples must be ignored
    tick(1'b0, 1'b0, 18'h3FFFF, mk("gate_all", MU, 3, 1'b0, 1'b0, 0));
    for (int k = 0; k < 4; k++)
      tick(1'b0, 1'b0, 18'($urandom), mk("gate_rnd", MU, 3, 1'b0, 1'b0, 0));
    tick(1'b0, 1'b0, oh(4), mk("gate_one", MU, 3, 1'b0, 1'b0, 0));
    do_reset("reset_sat");

    // 300 wraps saturate the lap counter
    for (int lap = 0; lap < 300; lap++)
      for (int i = 0; i < 18; i++)
        tick(1'b1, 1'b0, oh(i), nc());
    tick(1'b1, 1'b0, oh(0), mk("sat", MUP, 0, 1'b1, 1'b0, 255));
    tick(1'b1, 1'b0, oh(1), mk("sat_hold", MUP, 1, 1'b1, 1'b0, 255));
    tick(1'b0, 1'b0, '0, nc());
    tick(1'b0, 1'b0, '0, nc());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
